// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx
// -----------------------------------------------------------------------------
// Serial frame receiver. Samples `sin` once per rising clock edge, detects a
// start bit (a single 0 sample while idle), assembles DATA_W data bits LSB
// first, optionally checks one even-parity bit, checks the stop bit and
// presents the word on a valid/ready holding register.
//
// Optional feature macro: SIPO_FRAME_RX_PARITY_EN
//   defined   -> one even-parity bit follows the data bits, parity_err is live
//   undefined -> frame is start + DATA_W + stop, parity_err is tied to 0
//
// Ports:
//   clk        in   sampling clock, all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   sin        in   serial line, idle level 1
//   rx_ready   in   downstream accepts rx_data when rx_valid && rx_ready
//   rx_data    out  received word, bit 0 = first data bit on the line
//   rx_valid   out  rx_data holds an unconsumed word
//   busy       out  a frame is in progress (state other than IDLE)
//   frame_err  out  one-cycle pulse, stop bit sampled as 0
//   overrun    out  one-cycle pulse, good word dropped (holding register full)
//   parity_err out  one-cycle pulse, parity mismatch (0 without parity)
// -----------------------------------------------------------------------------
module sipo_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
`ifdef SIPO_FRAME_RX_PARITY_EN
    PARITY = 2'd2,
`endif
    STOP   = 2'd3
  } state_t;

  state_t             state_reg,     state_next;
  logic [CNT_W-1:0]   bit_cnt_reg,   bit_cnt_next;
  logic [DATA_W-1:0]  shift_reg,     shift_next;
  logic [DATA_W-1:0]  rx_data_reg,   rx_data_next;
  logic               rx_valid_reg,  rx_valid_next;
  logic               frame_err_reg, frame_err_next;
  logic               overrun_reg,   overrun_next;
  logic               last_bit;

`ifdef SIPO_FRAME_RX_PARITY_EN
  logic               par_bit_reg,    par_bit_next;
  logic               parity_err_reg, parity_err_next;
  logic               parity_ok;

  // Even parity: data bits plus the parity bit must XOR to 0.
  assign parity_ok = ~(^{shift_reg, par_bit_reg});
`endif

  // The counter holds the number of data bits already taken, so the sample
  // arriving while it equals DATA_W-1 is the last one.
  assign last_bit = (bit_cnt_reg == CNT_W'(DATA_W - 1));

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
`ifdef SIPO_FRAME_RX_PARITY_EN
      par_bit_reg    <= par_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    rx_data_next    = rx_data_reg;
    // A held word is released on an accepted handshake; a load in STOP
    // below overrides this so a same-edge drain and refill keeps valid high.
    rx_valid_next   = rx_valid_reg && !rx_ready;
    frame_err_next  = 1'b0;
    overrun_next    = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    par_bit_next    = par_bit_reg;
    parity_err_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (!sin) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end

      DATA: begin
        // Right shift with new bits entering at the MSB: the first data bit
        // ends up at bit 0 once all DATA_W bits are in.
        shift_next   = {sin, shift_reg[DATA_W-1:1]};
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        if (last_bit) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end

`ifdef SIPO_FRAME_RX_PARITY_EN
      PARITY: begin
        par_bit_next = sin;
        state_next   = STOP;
      end
`endif

      STOP: begin
        state_next = IDLE;
        if (!sin) begin
          frame_err_next = 1'b1;
        end
`ifdef SIPO_FRAME_RX_PARITY_EN
        else if (!parity_ok) begin
          parity_err_next = 1'b1;
        end
`endif
        else if (!rx_valid_reg || rx_ready) begin
          rx_data_next  = shift_reg;
          rx_valid_next = 1'b1;
        end else begin
          // Holding register is still occupied: keep the old word.
          overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
`ifdef SIPO_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx: frame-level reference model with a scoreboard.
// Stimulus pushes expected words/events; a negedge monitor pops and compares.
module tb_sipo_frame_rx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              sin;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  always #5 clk = ~clk;

  sipo_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  typedef enum logic [1:0] {EV_LOAD, EV_FERR, EV_PERR, EV_OVR} ev_t;

  ev_t               exp_evt[$];
  logic [DATA_W-1:0] exp_words[$];
  bit                m_full;       // model: holding register occupied
  int                ready_mode;   // 0 = ready low, 1 = ready high, 2 = random
  int                n_checks = 0;
  int                n_fail   = 0;
  ev_t               mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pick_ready();
    case (ready_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: one expected event per stop edge, words popped on handshakes.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_evt.size() > 0) begin
        mon_e = exp_evt.pop_front();
        case (mon_e)
          EV_LOAD: chk("load_pulses",   {28'd0, rx_valid, frame_err, parity_err, overrun}, 32'b1000);
          EV_FERR: chk("frame_err",     {29'd0, frame_err, parity_err, overrun}, 32'b100);
          EV_PERR: chk("parity_err",    {29'd0, frame_err, parity_err, overrun}, 32'b010);
          default: chk("overrun",       {29'd0, frame_err, parity_err, overrun}, 32'b001);
        endcase
      end else if (frame_err || parity_err || overrun) begin
        chk("spurious_pulse", {29'd0, frame_err, parity_err, overrun}, 32'b000);
      end
      if (rx_valid && rx_ready) begin
        if (exp_words.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h required none at %0t", rx_data, $time);
        end else begin
          chk("rx_data", {24'd0, rx_data}, {24'd0, exp_words.pop_front()});
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One sampled bit. Inputs change 2 time units after a rising edge; the model
  // acts at the edge that samples them. kind: 0 plain, 1 good stop,
  // 2 bad stop, 3 parity-bad stop.
  // ---------------------------------------------------------------------------
  task automatic step(input logic s, input logic r, input int kind, input logic [DATA_W-1:0] d);
    bit full_pre;
    sin      = s;
    rx_ready = r;
    @(posedge clk);
    full_pre = m_full;
    if (m_full && r) m_full = 1'b0;
    case (kind)
      1: begin
        if (!full_pre || r) begin
          m_full = 1'b1;
          exp_words.push_back(d);
          exp_evt.push_back(EV_LOAD);
        end else begin
          exp_evt.push_back(EV_OVR);
        end
      end
      2: exp_evt.push_back(EV_FERR);
      3: exp_evt.push_back(EV_PERR);
      default: ;
    endcase
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, pick_ready(), 0, '0);
  endtask

  // stop_ready < 0: use ready_mode on the stop edge, else force that level.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_bit,
                            input logic par_good, input int stop_ready);
    logic pg;
    logic r;
    int   k;
    pg = par_good;
`ifndef SIPO_FRAME_RX_PARITY_EN
    pg = 1'b1;
`endif
    step(1'b0, pick_ready(), 0, d);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < DATA_W; i++) step(d[i], pick_ready(), 0, d);
`ifdef SIPO_FRAME_RX_PARITY_EN
    step(pg ? ^d : ~^d, pick_ready(), 0, d);
`endif
    r = (stop_ready < 0) ? pick_ready() : (stop_ready != 0);
    if (!stop_bit)  k = 2;
    else if (!pg)   k = 3;
    else            k = 1;
    step(stop_bit, r, k, d);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"},    {24'd0, rx_data}, 32'd0);
    chk({tag, "_rx_valid"},   {31'd0, rx_valid}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy}, 32'd0);
    chk({tag, "_pulses"},     {29'd0, frame_err, parity_err, overrun}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    sin        = 1'b1;
    rx_ready   = 1'b0;
    ready_mode = 0;
    m_full     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(3);

    // Basic receive: A5 held with ready low, then drained.
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    chk("basic_valid", {31'd0, rx_valid}, 32'd1);
    chk("basic_data",  {24'd0, rx_data}, 32'hA5);
    ready_mode = 1;
    idle(2);

    // Frame error followed by a good frame.
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    chk("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, -1);
    idle(2);

    // Back-to-back with ready low -> overrun, then with ready high.
    ready_mode = 0;
    send_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    chk("overrun_hold", {24'd0, rx_data}, 32'h11);
    ready_mode = 1;
    idle(2);
    send_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    idle(2);

    // Accept on load: ready raised only for the stop edge of the second frame.
    ready_mode = 0;
    send_frame(8'h11, 1'b1, 1'b1, -1);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b1, 1);
    chk("aol_valid", {31'd0, rx_valid}, 32'd1);
    chk("aol_data",  {24'd0, rx_data}, 32'h22);
    ready_mode = 1;
    idle(2);

    // Reset after four data bits of a frame.
    ready_mode = 0;
    send_frame(8'h66, 1'b1, 1'b1, -1);   // leave a word held so reset must clear it
    step(1'b0, 1'b0, 0, '0);
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, 0, '0);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midframe");
    m_full = 1'b0;
    exp_words.delete();
    exp_evt.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    ready_mode = 1;
    idle(2);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    idle(2);

`ifdef SIPO_FRAME_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1);
    send_frame(8'h07, 1'b1, 1'b0, -1);
    idle(2);
`endif

    // Randomized frames, gaps and ready pattern.
    ready_mode = 2;
    for (int n = 0; n < 60; n++) begin
      send_frame(DATA_W'($urandom), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) != 0, -1);
      idle($urandom_range(0, 2));
    end

    ready_mode = 1;
    idle(4);
    chk("words_drained",  exp_words.size(), 32'd0);
    chk("events_drained", exp_evt.size(),   32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
